// File: rtl/logic_unit_seq.sv
// Registered eight-function bitwise logic unit with valid/ready direct path
// and a built-in truth-table sweep that folds results into a signature.
module logic_unit_seq #(
    parameter int WIDTH      = 8,
    parameter int SWEEP_BITS = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             mode,
    input  logic [2:0]       op,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] signature
);

    localparam int CW = 2 * SWEEP_BITS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [CW-1:0]     cnt;
    logic [2:0]        op_q;
    logic [WIDTH-1:0]  sweep_a;
    logic [WIDTH-1:0]  sweep_b;
    logic [WIDTH-1:0]  sweep_f;
    logic              xfer;
    logic              start_ok;
    logic              last_vec;

    function automatic logic [WIDTH-1:0] logic_fn(
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y,
        input logic [2:0]       sel
    );
        logic [WIDTH-1:0] r;
        unique case (sel)
            3'd0: r = x & y;
            3'd1: r = x | y;
            3'd2: r = x ^ y;
            3'd3: r = ~(x & y);
            3'd4: r = ~(x | y);
            3'd5: r = ~(x ^ y);
            3'd6: r = ~x;
            3'd7: r = ~y;
        endcase
        return r;
    endfunction

    // Sweep operands are the two halves of the vector counter, zero-extended.
    assign sweep_a  = {{(WIDTH-SWEEP_BITS){1'b0}}, cnt[SWEEP_BITS-1:0]};
    assign sweep_b  = {{(WIDTH-SWEEP_BITS){1'b0}}, cnt[CW-1:SWEEP_BITS]};
    assign sweep_f  = logic_fn(sweep_a, sweep_b, op_q);
    assign last_vec = &cnt;

    // Reset is folded in so no operand is accepted while rst is held.
    assign in_ready = ~rst & ena & ~mode & (state != RUN)
                    & (~out_valid | out_ready);
    assign xfer     = in_valid & in_ready;

    // A pending direct result must drain before a sweep may begin.
    assign start_ok = ena & mode & start & ~out_valid;

    // Next-state and status decode for the sweep sequencer.
    always_comb begin
        state_n = state;
        busy    = 1'b0;
        done    = 1'b0;
        case (state)
            IDLE: begin
                if (start_ok) state_n = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (ena && last_vec) state_n = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start_ok)
                    state_n = RUN;
                else if (ena && !mode)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Sweep state register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    // Direct-mode output stage: load on transfer, clear valid on drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
        end else if (ena) begin
            if (xfer) begin
                result    <= logic_fn(a, b, op);
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Sweep datapath: clear on entry, then fold one vector per enabled cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            signature <= '0;
            op_q      <= 3'd0;
        end else if (ena) begin
            if (state != RUN && state_n == RUN) begin
                cnt       <= '0;
                signature <= '0;
                op_q      <= op;
            end else if (state == RUN) begin
                signature <= {signature[WIDTH-2:0], signature[WIDTH-1]}
                           ^ sweep_f;
                if (!last_vec)
                    cnt <= cnt + {{(CW-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_logic_unit_seq.sv
// Directed self-checking bench for logic_unit_seq (WIDTH=8, SWEEP_BITS=1).
// Expected values are hand-computed constants.
module tb_logic_unit_seq;

    logic       clk;
    logic       rst;
    logic       ena;
    logic       mode;
    logic [2:0] op;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       start;
    logic       busy;
    logic       done;
    logic [7:0] signature;

    int checks = 0;
    int errors = 0;
    int n;

    logic_unit_seq #(.WIDTH(8), .SWEEP_BITS(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .mode      (mode),
        .op        (op),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .signature (signature)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_sweep(input logic [2:0] f, input logic [7:0] sig,
                             input string tag);
        mode  = 1'b1;
        op    = f;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, " done_clr"}, done, 0);
        n = 0;
        while (busy && n < 50) begin
            n++;
            tick();
        end
        chk({tag, " busy_cyc"}, n, 4);
        chk({tag, " done"}, done, 1);
        chk({tag, " sig"}, signature, sig);
    endtask

    initial begin
        rst = 1'b1; ena = 1'b1; mode = 1'b0; op = 3'd0;
        in_valid = 1'b0; a = 8'h00; b = 8'h00;
        out_ready = 1'b1; start = 1'b0;

        // 1. reset
        tick();
        tick();
        chk("rst in_ready", in_ready, 0);
        chk("rst out_valid", out_valid, 0);
        chk("rst result", result, 0);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst sig", signature, 0);
        rst = 1'b0;
        #1;
        chk("post-rst in_ready", in_ready, 1);

        // 2. direct mode, back-to-back
        a = 8'hF0; b = 8'h3C; op = 3'd2; in_valid = 1'b1;
        #1;
        chk("pre out_valid", out_valid, 0);
        tick();
        chk("xor valid", out_valid, 1);
        chk("xor result", result, 8'hCC);
        op = 3'd3;
        tick();
        chk("nand result", result, 8'hCF);
        op = 3'd7;
        tick();
        chk("notb result", result, 8'hC3);
        in_valid = 1'b0;
        tick();
        chk("drain valid", out_valid, 0);
        chk("drain hold", result, 8'hC3);

        // 3. backpressure
        out_ready = 1'b0; op = 3'd2; in_valid = 1'b1;
        tick();
        chk("bp result1", result, 8'hCC);
        op = 3'd4;
        #1;
        chk("bp in_ready", in_ready, 0);
        tick();
        chk("bp hold result", result, 8'hCC);
        chk("bp hold valid", out_valid, 1);
        out_ready = 1'b1;
        #1;
        chk("bp release ready", in_ready, 1);
        tick();
        chk("bp result2", result, 8'h03);
        chk("bp valid2", out_valid, 1);
        in_valid = 1'b0;
        tick();
        chk("bp drain", out_valid, 0);

        // 4. sweeps
        run_sweep(3'd0, 8'h01, "sw and");
        run_sweep(3'd2, 8'h06, "sw xor");
        run_sweep(3'd3, 8'h01, "sw nand");

        // 5. start mid-RUN ignored, op change ignored
        mode = 1'b1; op = 3'd2; start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (busy && n < 50) begin
            n++;
            if (n == 2) begin
                start = 1'b1;
                op    = 3'd0;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        chk("midstart cyc", n, 4);
        chk("midstart sig", signature, 8'h06);
        run_sweep(3'd2, 8'h06, "rerun");

        // DONE with mode=0 returns to IDLE, signature held
        mode = 1'b0;
        tick();
        chk("idle done", done, 0);
        chk("idle sig", signature, 8'h06);

        // pending result blocks start
        out_ready = 1'b0; op = 3'd0; a = 8'hF0; b = 8'h3C; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; mode = 1'b1; start = 1'b1;
        tick();
        chk("blocked busy", busy, 0);
        out_ready = 1'b1;
        tick();
        chk("blocked busy2", busy, 0);
        chk("blocked drained", out_valid, 0);
        op = 3'd1;
        tick();
        chk("unblocked busy", busy, 1);
        start = 1'b0;
        n = 0;
        while (busy && n < 50) begin
            n++;
            tick();
        end
        // OR: 0,1,1,1 -> 00,01,03,07
        chk("or sig", signature, 8'h07);

        // 6. reset on cycle 2 of a sweep
        op = 3'd2; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst busy", busy, 0);
        chk("midrst done", done, 0);
        chk("midrst sig", signature, 0);

        // ena low three cycles mid-sweep
        op = 3'd2; start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (busy && n < 50) begin
            n++;
            ena = (n >= 2 && n <= 4) ? 1'b0 : 1'b1;
            tick();
        end
        ena = 1'b1;
        chk("ena busy cyc", n, 7);
        chk("ena sig", signature, 8'h06);
        chk("ena done", done, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
